aes_keyexp_ctrl: RTL and testbench

Sequencer for AES-128 key expansion. It loads a 128-bit cipher key, runs the 10-round schedule one round at a time through a shared S-box, and stores all 11 round keys in an internal register file. Each round chains RotWord, SubWord, Rcon and the four-word XOR cascade. The cipher datapath reads round keys through a combinational read port. The S-box is borrowed from the cipher datapath through a req/gnt handshake.

---
 rtl/aes_keyexp_ctrl.sv | 103 ++++++++++
 tb/tb_aes_keyexp_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_keyexp_ctrl.sv
// AES-128 key expansion sequencer: one round per SUB/XOR pair,
// S-box borrowed over req/gnt, all 11 round keys held locally.
module aes_keyexp_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         sbox_req_o,
    input  logic         sbox_gnt_i,
    output logic [31:0]  sbox_in_o,
    input  logic [31:0]  sbox_out_i,
    input  logic [3:0]   rd_idx_i,
    output logic [127:0] rd_key_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         key_valid_o
);

    typedef enum logic [2:0] {
        IDLE, LOAD, SUB, XOR, DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t       state, state_nxt;
    logic [127:0] key_q;
    logic [127:0] rk [0:NR];
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [7:0]   rcon_nxt;
    logic [31:0]  t;
    logic         key_valid;
    logic [127:0] prev;
    logic [31:0]  n0, n1, n2, n3;

    assign prev     = rk[round - 4'd1];
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    // Four-word XOR cascade over the previous round key
    assign n0 = t  ^ prev[127:96];
    assign n1 = n0 ^ prev[95:64];
    assign n2 = n1 ^ prev[63:32];
    assign n3 = n2 ^ prev[31:0];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round     <= 4'd0;
            rcon      <= 8'h01;
            t         <= '0;
            key_q     <= '0;
            key_valid <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        key_q     <= key_i;
                        key_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    rk[0] <= key_q;
                    round <= 4'd1;
                    rcon  <= 8'h01;
                end
                SUB: begin
                    if (sbox_gnt_i) t <= sbox_out_i ^ {rcon, 24'h0};
                end
                XOR: begin
                    rk[round] <= {n0, n1, n2, n3};
                    rcon      <= rcon_nxt;
                    if (round != LAST) round <= round + 4'd1;
                end
                DONE: key_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = LOAD;
            LOAD: state_nxt = SUB;
            SUB:  if (sbox_gnt_i) state_nxt = XOR;
            XOR:  state_nxt = (round == LAST) ? DONE : SUB;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign key_valid_o = key_valid;
    assign sbox_req_o  = (state == SUB);
    assign sbox_in_o   = sbox_req_o ? {prev[23:0], prev[31:24]} : 32'h0;
    assign rd_key_o    = (rd_idx_i <= LAST) ? rk[rd_idx_i] : '0;

endmodule

// File: tb/tb_aes_keyexp_ctrl.sv
// Bench for aes_keyexp_ctrl: FIPS-197 vectors plus random keys and
// random S-box stalls checked against a word-level key schedule model.
module tb_aes_keyexp_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         sbox_req_o;
    logic         sbox_gnt_i = 1'b1;
    logic [31:0]  sbox_in_o;
    logic [31:0]  sbox_out_i;
    logic [3:0]   rd_idx_i = '0;
    logic [127:0] rd_key_o;
    logic         busy_o;
    logic         done_o;
    logic         key_valid_o;

    aes_keyexp_ctrl #(.NR(10)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .key_i       (key_i),
        .sbox_req_o  (sbox_req_o),
        .sbox_gnt_i  (sbox_gnt_i),
        .sbox_in_o   (sbox_in_o),
        .sbox_out_i  (sbox_out_i),
        .rd_idx_i    (rd_idx_i),
        .rd_key_o    (rd_key_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .key_valid_o (key_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk1;
        logic [127:0] rk10;
        bit           abort_first;
    } vec_t;

    vec_t         tab [2];
    logic [7:0]   sbox_tab [256];
    logic [127:0] mrk [11];
    int           nvec = 0;
    int           nfail = 0;
    int           gnt_mode = 0;
    int           stalls = 0;
    int           stall_left = 0;
    bit           was_stall = 0;
    logic [31:0]  held_in = '0;

    assign sbox_out_i = {sbox_tab[sbox_in_o[31:24]],
                         sbox_tab[sbox_in_o[23:16]],
                         sbox_tab[sbox_in_o[15:8]],
                         sbox_tab[sbox_in_o[7:0]]};

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(logic [7:0] a);
        logic [7:0] b = 8'h00;
        if (a != 8'h00)
            for (int x = 1; x < 256; x++)
                if (gmul(a, 8'(x)) == 8'h01) b = 8'(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]],
                sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // FIPS-197 word-array key schedule
    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++)
            mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string nm, input logic [127:0] got,
                         input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Random S-box stalls: 0-5 low cycles before each grant
    always @(negedge clk_i) begin
        if (gnt_mode == 0) begin
            sbox_gnt_i = 1'b1;
            was_stall  = 0;
        end else if (sbox_req_o) begin
            if (was_stall) check("sbox_in_hold", 128'(sbox_in_o), 128'(held_in));
            if (stall_left == 0) begin
                sbox_gnt_i = 1'b1;
                stall_left = $urandom_range(0, 5);
                was_stall  = 0;
            end else begin
                sbox_gnt_i = 1'b0;
                stall_left--;
                stalls++;
                was_stall  = 1;
                held_in    = sbox_in_o;
            end
        end else begin
            sbox_gnt_i = 1'($urandom_range(0, 1));
            was_stall  = 0;
        end
    end

    task automatic run(input logic [127:0] k, input bit glitch);
        int cyc, dn, dat;
        stalls = 0;
        start_i = 1'b1;
        key_i   = k;
        @(negedge clk_i);
        start_i = 1'b0;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        check("key_valid_clear", 128'(key_valid_o), 128'(0));
        cyc = 0;
        dn  = 0;
        dat = 0;
        while (busy_o && cyc < 400) begin
            cyc++;
            if (done_o) begin
                dn++;
                dat = cyc;
            end
            start_i = glitch && (cyc == 6 || cyc == 14);
            if (start_i) key_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check("busy_cycles", 128'(cyc), 128'(22 + stalls));
        check("done_cycle", 128'(dat), 128'(22 + stalls));
        check("done_pulses", 128'(dn), 128'(1));
        check("key_valid_set", 128'(key_valid_o), 128'(1));
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 16; i++) begin
            rd_idx_i = 4'(i);
            #1;
            check(nm, rd_key_o, (i <= 10) ? mrk[i] : 128'h0);
        end
    endtask

    task automatic abort_run(input logic [127:0] k);
        start_i = 1'b1;
        key_i   = k;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_valid", 128'(key_valid_o), 128'(0));
        check("rst_req", 128'(sbox_req_o), 128'(0));
        check("rst_sbox_in", 128'(sbox_in_o), 128'(0));
        for (int i = 0; i < 11; i += 5) begin
            rd_idx_i = 4'(i);
            #1;
            check("rst_rk", rd_key_o, 128'h0);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
    endtask

    initial begin
        logic [127:0] rk_a;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        tab[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'ha0fafe1788542cb123a339392a6c7605,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};
        tab[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                   128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                   128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};

        @(negedge clk_i);
        check("reset_busy", 128'(busy_o), 128'(0));
        check("reset_done", 128'(done_o), 128'(0));
        check("reset_valid", 128'(key_valid_o), 128'(0));
        check("reset_req", 128'(sbox_req_o), 128'(0));
        check("reset_rk0", rd_key_o, 128'h0);
        rst_n = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 2; i++) begin
            gnt_mode = 0;
            if (tab[i].abort_first)
                abort_run({$urandom, $urandom, $urandom, $urandom});
            model(tab[i].key);
            run(tab[i].key, 1'b0);
            rd_idx_i = 4'd1;
            #1;
            check("vec_rk1", rd_key_o, tab[i].rk1);
            rd_idx_i = 4'd10;
            #1;
            check("vec_rk10", rd_key_o, tab[i].rk10);
            sweep("vec_sweep");
            @(negedge clk_i);
        end

        model(tab[0].key);
        run(tab[0].key, 1'b1);
        sweep("glitch_sweep");
        @(negedge clk_i);

        gnt_mode = 1;
        for (int n = 0; n < 6; n++) begin
            rk_a = {$urandom, $urandom, $urandom, $urandom};
            model(rk_a);
            run(rk_a, n[0]);
            sweep("rand_sweep");
            @(negedge clk_i);
        end

        model(tab[0].key);
        run(tab[0].key, 1'b0);
        sweep("stall_fips_sweep");
        gnt_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
